adxl362_sampler: RTL

Command sequencer directly upstream of adxl362_controller. It drives the controller's start/write/address/data_to_send inputs and consumes busy/done/data_received. After reset it initialises the ADXL362 (soft reset, ID check, measurement mode). It then periodically reads the X/Y/Z 8-bit data registers and presents them as a registered sample with a one-cycle valid strobe.

---
 rtl/adxl362_pkg.sv | 32 +++
 rtl/adxl362_sampler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants and state type for the ADXL362 command sequencer.
// Register addresses and command codes follow the ADXL362 register map.
package adxl362_pkg;

    // Register addresses
    localparam logic [7:0] DEVID_AD   = 8'h00;
    localparam logic [7:0] PARTID     = 8'h02;
    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] YDATA      = 8'h09;
    localparam logic [7:0] ZDATA      = 8'h0A;
    localparam logic [7:0] STATUS     = 8'h0B;
    localparam logic [7:0] SOFT_RESET = 8'h1F;
    localparam logic [7:0] POWER_CTL  = 8'h2D;

    // Command / expected values
    localparam logic [7:0] SOFT_RESET_CODE = 8'h52;
    localparam logic [7:0] MEASURE_MODE    = 8'h02;
    localparam logic [7:0] DEVID_VALUE     = 8'hAD;

    typedef enum logic [3:0] {
        StRstWr,
        StRstWait,
        StIdRd,
        StPwrWr,
        StIdle,
        StRdStat,
        StRdX,
        StRdY,
        StRdZ
    } sampler_state_e;

endpackage

// File: rtl/adxl362_sampler.sv
// ADXL362 command sequencer: initialises the part (soft reset, ID check,
// measurement mode) then periodically reads X/Y/Z through the register
// controller and publishes them with a one-cycle sample_valid strobe.
// Optional: define ADXL362_STATUS_EN to poll STATUS.DATA_READY before each
// X/Y/Z read and expose the last STATUS byte on status_reg.
module adxl362_sampler
    import adxl362_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY     = 100_000_000,
    parameter int unsigned SAMPLE_RATE       = 100,
    parameter int unsigned RESET_WAIT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       ctrl_start,
    output logic       ctrl_write,
    output logic [7:0] ctrl_address,
    output logic [7:0] ctrl_data_to_send,
    input  logic       ctrl_busy,
    input  logic       ctrl_done,
    input  logic [7:0] ctrl_data_received,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic [7:0] z_data,
    output logic       sample_valid,
`ifdef ADXL362_STATUS_EN
    output logic [7:0] status_reg,
`endif
    output logic       init_done,
    output logic       device_ok
);

    localparam int unsigned SAMPLE_PERIOD = CLK_FREQUENCY / SAMPLE_RATE;
    localparam int unsigned PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned WAIT_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT_CYCLES - 1);

`ifdef ADXL362_STATUS_EN
    localparam sampler_state_e FIRST_READ = StRdStat;
`else
    localparam sampler_state_e FIRST_READ = StRdX;
`endif

    sampler_state_e    state_q, state_d;
    logic              pending_q, pending_d;
    logic              start_q, start_d;
    logic              write_q, write_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [7:0]        x_sh_q, x_sh_d;
    logic [7:0]        y_sh_q, y_sh_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        z_q, z_d;
    logic              valid_q, valid_d;
    logic              init_done_q, init_done_d;
    logic              device_ok_q, device_ok_d;
    logic [7:0]        status_q, status_d;

    logic       txn_done;
    logic       can_issue;
    logic       period_run;
    logic       period_hit;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_data;

    // A done pulse only counts when this block has a transaction in flight.
    assign txn_done  = pending_q & ctrl_done;
    assign can_issue = ~pending_q & ~ctrl_busy & ~start_q;

    // Period counter runs through IDLE and the read sequence so sample spacing is exact.
    assign period_run = enable & (state_q inside {StIdle, StRdStat, StRdX, StRdY, StRdZ});
    assign period_hit = period_run & (period_q == PER_LAST);

    // Next-state, transaction request and publish logic.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        start_d     = 1'b0;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        x_sh_d      = x_sh_q;
        y_sh_d      = y_sh_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        device_ok_d = device_ok_q;
        status_d    = status_q;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 8'h00;
        req_data    = 8'h00;

        if (!period_run || period_hit) begin
            period_d = '0;
        end else begin
            period_d = period_q + 1'b1;
        end

        if (txn_done) begin
            pending_d = 1'b0;
        end

        case (state_q)
            StRstWr: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = SOFT_RESET;
                req_data  = SOFT_RESET_CODE;
                if (txn_done) begin
                    wait_d  = '0;
                    state_d = StRstWait;
                end
            end
            StRstWait: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = StIdRd;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StIdRd: begin
                req_valid = 1'b1;
                req_addr  = DEVID_AD;
                if (txn_done) begin
                    device_ok_d = (ctrl_data_received == DEVID_VALUE);
                    state_d     = StPwrWr;
                end
            end
            StPwrWr: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = POWER_CTL;
                req_data  = MEASURE_MODE;
                if (txn_done) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StIdle: begin
                if (period_hit) begin
                    state_d = FIRST_READ;
                end
            end
`ifdef ADXL362_STATUS_EN
            StRdStat: begin
                req_valid = 1'b1;
                req_addr  = STATUS;
                if (txn_done) begin
                    status_d = ctrl_data_received;
                    // No fresh data: skip this period and retry at the next one.
                    state_d  = ctrl_data_received[0] ? StRdX : StIdle;
                end
            end
`endif
            StRdX: begin
                req_valid = 1'b1;
                req_addr  = XDATA;
                if (txn_done) begin
                    x_sh_d  = ctrl_data_received;
                    state_d = StRdY;
                end
            end
            StRdY: begin
                req_valid = 1'b1;
                req_addr  = YDATA;
                if (txn_done) begin
                    y_sh_d  = ctrl_data_received;
                    state_d = StRdZ;
                end
            end
            StRdZ: begin
                req_valid = 1'b1;
                req_addr  = ZDATA;
                if (txn_done) begin
                    x_d     = x_sh_q;
                    y_d     = y_sh_q;
                    z_d     = ctrl_data_received;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StRstWr;
            end
        endcase

        // Launch the state's transaction once; command fields stay frozen until the next launch.
        if (req_valid && can_issue && !txn_done) begin
            start_d   = 1'b1;
            pending_d = 1'b1;
            write_d   = req_write;
            addr_d    = req_addr;
            wdata_d   = req_data;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRstWr;
            pending_q   <= 1'b0;
            start_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            wait_q      <= '0;
            period_q    <= '0;
            x_sh_q      <= 8'h00;
            y_sh_q      <= 8'h00;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            z_q         <= 8'h00;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            device_ok_q <= 1'b0;
            status_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            start_q     <= start_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            period_q    <= period_d;
            x_sh_q      <= x_sh_d;
            y_sh_q      <= y_sh_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            device_ok_q <= device_ok_d;
            status_q    <= status_d;
        end
    end

    assign ctrl_start        = start_q;
    assign ctrl_write        = write_q;
    assign ctrl_address      = addr_q;
    assign ctrl_data_to_send = wdata_q;
    assign x_data            = x_q;
    assign y_data            = y_q;
    assign z_data            = z_q;
    assign sample_valid      = valid_q;
    assign init_done         = init_done_q;
    assign device_ok         = device_ok_q;
`ifdef ADXL362_STATUS_EN
    assign status_reg        = status_q;
`endif

endmodule
